mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use these parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits
- TIMEOUT, 64, memory-ack wait limit in cycles; 0 disables the timeout

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  instruction-fetch request
- if_addr  in  AW  fetch address
- if_ack  out  1  fetch-complete pulse
- if_err  out  1  fetch timed out; valid with if_ack
- if_rdata  out  DW  fetched word; valid with if_ack
- d_req  in  1  data (load/store) request
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  data-complete pulse
- d_err  out  1  data access timed out; valid with d_ack
- d_rdata  out  DW  load data; valid with d_ack
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write strobe
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle

Function
REQ-003 Requester rules: each requester SHALL hold req and its payload stable from assertion until it samples its own ack high; each ack SHALL be exactly one cycle wide.

REQ-004 FSM states SHALL be IDLE, BUSY_IF and BUSY_D, and only IDLE SHALL make grant decisions.

REQ-005 IDLE grant rule: grant D if d_req and not starve; else grant IF if if_req; else stay IDLE. Starve = if_req && streak == MAX_D_STREAK.

REQ-006 A requester whose ack is high in the current cycle SHALL NOT be granted in that cycle, because its stale req is still asserted.

REQ-007 On a grant, at the next edge the block SHALL register the payload onto mem_* (IF grant: mem_we=0, mem_be all ones, mem_wdata=0), set mem_req=1 and enter BUSY_IF or BUSY_D.

REQ-008 In BUSY_x, mem_req and the mem_* payload SHALL stay constant until mem_ack is sampled.

REQ-009 When mem_ack is sampled in BUSY_x, at the next edge the block SHALL:
- clear mem_req;
- pulse x_ack=1 with x_err=0;
- drive x_rdata=mem_rdata (0 for stores);
- enter IDLE.

REQ-010 Minimum latency SHALL be 2 cycles from req sampled to ack high, when memory acks in the first mem_req cycle.

REQ-011 Streak counter: increment, saturating at MAX_D_STREAK, on each D grant; clear to 0 on each IF grant; no change otherwise.

REQ-012 Timeout counter: clear on each grant; increment each BUSY cycle without mem_ack.

REQ-013 On reaching TIMEOUT (when TIMEOUT>0), at the next edge the block SHALL:
- clear mem_req;
- pulse x_ack=1 and x_err=1 with x_rdata=0;
- enter IDLE.

REQ-014 mem_ack arriving while in IDLE, or in the same cycle the timeout fires, SHALL be ignored.

REQ-015 All outputs SHALL be registered, and x_rdata/x_err SHALL hold their values between acks.

Reset
REQ-016 While rst_n=0 at a rising edge:
- state SHALL become IDLE;
- streak and timeout counters SHALL clear;
- every output (mem_*, if_*, d_*) SHALL become 0.

REQ-017 Reset mid-transaction SHALL abandon the transaction without producing an ack, and any later mem_ack for it SHALL be ignored (REQ-014).

REQ-018 The first grant after reset release SHALL be possible at the first edge with rst_n=1.

Verification
REQ-019 Single fetch: if_req, if_addr=0x100, memory acks in 1 cycle with 0xDEADBEEF -> if_ack high at cycle 2, if_rdata=0xDEADBEEF, if_err=0, mem_req high for exactly 1 cycle.

REQ-020 Simultaneous requests, streak=0: if_req and d_req (d_we=1, d_addr=0x200, d_wdata=0x1234, d_be=0xF) together -> store issued first with mem_we=1, d_ack, then fetch issued; mem_addr sequence 0x200, 0x100.

REQ-021 Anti-starvation: d_req held continuously for 6 loads plus constant if_req, memory 1-cycle ack -> grant order D, D, D, D, IF, D, D; streak reads 4 before the IF grant and 0 after it.

REQ-022 Timeout: TIMEOUT=8, d_req load with mem_ack never asserted -> d_ack=1, d_err=1, d_rdata=0 exactly 9 cycles after mem_req rises; a mem_ack arriving afterwards causes no ack.

REQ-023 Reset mid-operation: rst_n=0 for 1 cycle while in BUSY_IF with memory stalled -> mem_req=0 and no if_ack; a mem_ack 2 cycles later is ignored; if_req re-sampled afterwards yields a fresh grant with mem_req=1.

REQ-024 Back-to-back same requester: the fetcher raises if_req again in the cycle after if_ack -> no double grant during the if_ack cycle; the second fetch is issued exactly one cycle after the ack cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the data port wins unless the fetch port has been passed over
// MAX_D_STREAK times in a row. Only one transaction is in flight, with an optional ack timeout.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic            if_err,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic            d_err,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  localparam int unsigned   SW        = $clog2(MAX_D_STREAK + 2);
  localparam int unsigned   TW        = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TmoMax    = TW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic              starve, tmo_hit, grant_if, grant_d, done_ok, done_tmo;

  assign starve  = if_req && (streak_q == StreakMax);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TmoMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    unique case (state_q)
      StIdle: begin
        // No grant while an ack is out: the acked requester still shows its stale req, and
        // pausing both ports lets a streaming data requester keep its turn.
        if (!(if_ack_q || d_ack_q)) begin
          if (d_req && !starve) begin
            grant_d = 1'b1;
            state_d = StBusyD;
          end else if (if_req) begin
            grant_if = 1'b1;
            state_d  = StBusyIf;
          end
        end
      end
      StBusyIf, StBusyD: begin
        if (tmo_hit) begin
          done_tmo = 1'b1;
          state_d  = StIdle;
        end else if (mem_ack) begin
          done_ok = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = if_err_q;
    if_rdata_d  = if_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = d_err_q;
    d_rdata_d   = d_rdata_q;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_be_d    = d_be;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      tmo_d       = '0;
      if (streak_q != StreakMax) streak_d = streak_q + SW'(1);
    end
    if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = '1;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      tmo_d       = '0;
      streak_d    = '0;
    end
    if ((state_q != StIdle) && !mem_ack && !tmo_hit && (TIMEOUT != 0)) tmo_d = tmo_q + TW'(1);
    if (done_ok || done_tmo) begin
      mem_req_d = 1'b0;
      if (state_q == StBusyIf) begin
        if_ack_d   = 1'b1;
        if_err_d   = done_tmo;
        if_rdata_d = done_ok ? mem_rdata : '0;
      end else begin
        d_ack_d   = 1'b1;
        d_err_d   = done_tmo;
        d_rdata_d = (done_ok && !mem_we_q) ? mem_rdata : '0;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the grant, streak and completion rules.
module tb_mem_arbiter;
  localparam int unsigned MaxStreak = 4;
  localparam int unsigned Tmo       = 8;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [69:0] mem_bus;
  logic [33:0] if_rsp, d_rsp;
  assign mem_bus = {mem_req, mem_we, mem_be, mem_addr, mem_wdata};
  assign if_rsp  = {if_ack, if_err, if_rdata};
  assign d_rsp   = {d_ack, d_err, d_rdata};

  int n_vec, n_err;

  mem_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(MaxStreak), .TIMEOUT(Tmo)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h1234; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    d_addr = 32'h5678; d_wdata = 32'hFFFF; mem_ack = 1'b1; mem_rdata = 32'h9999;
    tick();
    n_vec++;
    if (mem_bus !== 70'h0) begin
      n_err++; $display("FAIL reset_mem got=%h exp=0", mem_bus);
    end
    n_vec++;
    if (if_rsp !== 34'h0) begin
      n_err++; $display("FAIL reset_if got=%h exp=0", if_rsp);
    end
    n_vec++;
    if (d_rsp !== 34'h0) begin
      n_err++; $display("FAIL reset_d got=%h exp=0", d_rsp);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    rst_n = 1'b0; idle_inputs();
    tick();
    // request presented together with reset release: granted at that first edge
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      n_err++; $display("FAIL sf_issue got=%h", mem_bus);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    n_vec++;
    if (if_rsp !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL sf_ack got=%h exp=%h", if_rsp, {1'b1, 1'b0, 32'hDEADBEEF});
    end
    n_vec++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL sf_req_width got=%b exp=0", mem_req);
    end
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    n_vec++;
    if ({mem_req, if_rsp} !== {1'b0, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL sf_hold got=%h", {mem_req, if_rsp});
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234; d_be = 4'hF;
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b1, 4'hF, 32'h200, 32'h1234}) begin
      n_err++; $display("FAIL sim_first got=%h", mem_bus);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    n_vec++;
    if ({d_rsp, if_ack} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL sim_dack got=%h", {d_rsp, if_ack});
    end
    mem_ack = 1'b0;
    tick();
    d_req = 1'b0;
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
      n_err++; $display("FAIL sim_second got=%h", mem_bus);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    n_vec++;
    if (if_rsp !== {1'b1, 1'b0, 32'h0BADF00D}) begin
      n_err++; $display("FAIL sim_ifack got=%h", if_rsp);
    end
    mem_ack = 1'b0;
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [6:0] order;
    int         n_grant, n_load;
    bit         adv;
    logic       prev_req;
    do_reset();
    order = '0; n_grant = 0; n_load = 0; adv = 1'b0; prev_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (adv) begin
        adv = 1'b0;
        n_load++;
        if (n_load == 6) d_req = 1'b0;
        else d_addr = 32'h400 + 32'(4 * n_load);
      end
      if (mem_req && !prev_req && n_grant < 7) begin
        order[n_grant] = (mem_addr != 32'h300);
        n_grant++;
      end
      prev_req = mem_req;
      if (d_ack) begin
        n_vec++;
        if (d_rdata !== (d_addr ^ 32'hA5A50000)) begin
          n_err++; $display("FAIL stv_load got=%h exp=%h", d_rdata, d_addr ^ 32'hA5A50000);
        end
        adv = 1'b1;
      end
      mem_ack = mem_req; mem_rdata = mem_addr ^ 32'hA5A50000;
    end
    n_vec++;
    if (n_grant != 7) begin
      n_err++; $display("FAIL stv_count got=%0d exp=7", n_grant);
    end
    // bit i = grant i went to data: D D D D IF D D
    n_vec++;
    if (order !== 7'b1101111) begin
      n_err++; $display("FAIL stv_order got=%b exp=1101111", order);
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      mem_ack = mem_req;
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int first;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4F0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    tick();
    d_req = 1'b0;
    tick();
    n_vec++;
    if (d_rsp !== {1'b0, 1'b0, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL tmo_preload got=%h", d_rsp);
    end
    for (int run = 0; run < 2; run++) begin
      d_req = 1'b1; d_addr = 32'h500;
      tick();
      n_vec++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
        n_err++; $display("FAIL tmo_issue run=%0d got=%h", run, {mem_req, mem_addr});
      end
      first = -1;
      for (int k = 1; k <= 12 && first < 0; k++) begin
        // run 1: memory answers in the cycle the timeout fires and must be ignored
        mem_ack = (run == 1 && k == 9); mem_rdata = 32'h11111111;
        tick();
        if (d_ack) first = k;
      end
      mem_ack = 1'b0;
      n_vec++;
      if (first != 9) begin
        n_err++; $display("FAIL tmo_latency run=%0d got=%0d exp=9", run, first);
      end
      n_vec++;
      if ({d_err, d_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin
        n_err++; $display("FAIL tmo_resp run=%0d got=%h", run, {d_err, d_rdata, mem_req});
      end
      tick();
      d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
      for (int k = 0; k < 2; k++) begin
        tick();
        n_vec++;
        if ({d_ack, mem_req, d_err, d_rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
          n_err++; $display("FAIL tmo_late run=%0d got=%h", run, {d_ack, mem_req, d_err, d_rdata});
        end
      end
      mem_ack = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b0, 4'hF, 32'h600, 32'h0}) begin
      n_err++; $display("FAIL rm_stall got=%h", mem_bus);
    end
    rst_n = 1'b0; if_req = 1'b0;
    tick();
    n_vec++;
    if ({mem_req, if_rsp} !== 35'h0) begin
      n_err++; $display("FAIL rm_abandon got=%h", {mem_req, if_rsp});
    end
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    n_vec++;
    if ({mem_req, if_rsp} !== 35'h0) begin
      n_err++; $display("FAIL rm_stale_ack got=%h", {mem_req, if_rsp});
    end
    mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h700;
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b0, 4'hF, 32'h700, 32'h0}) begin
      n_err++; $display("FAIL rm_regrant got=%h", mem_bus);
    end
    mem_ack = 1'b1; mem_rdata = 32'h2468ACE0;
    tick();
    n_vec++;
    if (if_rsp !== {1'b1, 1'b0, 32'h2468ACE0}) begin
      n_err++; $display("FAIL rm_ack got=%h", if_rsp);
    end
    mem_ack = 1'b0;
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11110000;
    tick();
    n_vec++;
    if (if_rsp !== {1'b1, 1'b0, 32'h11110000}) begin
      n_err++; $display("FAIL b2b_ack1 got=%h", if_rsp);
    end
    mem_ack = 1'b0;
    tick();
    n_vec++;
    if ({mem_req, if_ack} !== 2'b00) begin
      n_err++; $display("FAIL b2b_no_double got=%b exp=00", {mem_req, if_ack});
    end
    // next fetch presented in the cycle after the ack; granted at that cycle's end
    if_addr = 32'h804;
    tick();
    n_vec++;
    if (mem_bus !== {1'b1, 1'b0, 4'hF, 32'h804, 32'h0}) begin
      n_err++; $display("FAIL b2b_second got=%h", mem_bus);
    end
    mem_ack = 1'b1; mem_rdata = 32'h22220000;
    tick();
    n_vec++;
    if (if_rsp !== {1'b1, 1'b0, 32'h22220000}) begin
      n_err++; $display("FAIL b2b_ack2 got=%h", if_rsp);
    end
    mem_ack = 1'b0;
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit          if_on, d_on, if_adv, d_adv, ack_now, exp_req, nxt_if, nxt_d, cur_we;
    int          if_gap, d_gap, busy, lat, streak;
    logic [69:0] exp_bus;
    logic [32:0] exp_if_hold, exp_d_hold;
    do_reset();
    if_on = 0; d_on = 0; if_adv = 0; d_adv = 0; ack_now = 0; exp_req = 0; cur_we = 0;
    if_gap = 0; d_gap = 1; busy = 0; lat = 0; streak = 0;
    exp_bus = '0; exp_if_hold = '0; exp_d_hold = '0;
    for (int c = 0; c < 600; c++) begin
      if (if_adv) begin if_adv = 0; if_on = 0; if_gap = $urandom_range(0, 2); end
      if (d_adv) begin d_adv = 0; d_on = 0; d_gap = $urandom_range(0, 2); end
      if (!if_on) begin
        if (if_gap == 0) begin if_on = 1; if_addr = {1'b0, 29'($urandom), 2'b00}; end
        else if_gap--;
      end
      if (!d_on) begin
        if (d_gap == 0) begin
          d_on = 1; d_addr = {1'b1, 29'($urandom), 2'b00}; d_we = 1'($urandom);
          d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom;
        end else d_gap--;
      end
      if_req = if_on; d_req = d_on;
      mem_rdata = $urandom;
      if (busy != 0 && lat == 0) mem_ack = 1'b1;
      else begin
        mem_ack = (busy == 0) && ($urandom_range(0, 7) == 0);
        if (busy != 0) lat--;
      end
      nxt_if = 0; nxt_d = 0;
      if (busy != 0 && mem_ack) begin
        if (busy == 1) begin nxt_if = 1; exp_if_hold = {1'b0, mem_rdata}; end
        else begin nxt_d = 1; exp_d_hold = {1'b0, cur_we ? 32'h0 : mem_rdata}; end
        busy = 0; exp_req = 0;
      end else if (busy == 0 && !ack_now && (if_on || d_on)) begin
        if (d_on && !(if_on && streak == MaxStreak)) begin
          busy = 2; cur_we = d_we;
          if (streak < MaxStreak) streak++;
          exp_bus = {1'b1, d_we, d_be, d_addr, d_wdata};
        end else begin
          busy = 1; streak = 0;
          exp_bus = {1'b1, 1'b0, 4'hF, if_addr, 32'h0};
        end
        lat = $urandom_range(0, 3); exp_req = 1;
      end
      ack_now = nxt_if || nxt_d;
      tick();
      n_vec++;
      if (mem_req !== exp_req) begin
        n_err++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      if (exp_req) begin
        n_vec++;
        if (mem_bus !== exp_bus) begin
          n_err++; $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, mem_bus, exp_bus);
        end
      end
      n_vec++;
      if (if_rsp !== {nxt_if, exp_if_hold}) begin
        n_err++; $display("FAIL rnd_if c=%0d got=%h exp=%h", c, if_rsp, {nxt_if, exp_if_hold});
      end
      n_vec++;
      if (d_rsp !== {nxt_d, exp_d_hold}) begin
        n_err++; $display("FAIL rnd_d c=%0d got=%h exp=%h", c, d_rsp, {nxt_d, exp_d_hold});
      end
      if (nxt_if) if_adv = 1;
      if (nxt_d) d_adv = 1;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
